i2c_cmd_arbiter: RTL and testbench

- Shares one i2c_master_wrapper command/write/read channel set between p_num_req requesters, e.g. the ROM config parser and a debug register poke/peek path.
- Round-robin arbitration at command granularity. The grant is locked for the whole transaction: one command plus its burst_num+1 write or read beats.
- Read bytes are routed back to the requester that issued the read.
- Sits between the requesters and the i2c_master_wrapper, which is instantiated with CMD_FIFO=0.

---
 rtl/i2c_cmd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one i2c master cmd/write/read channel set between requesters.
// Optional feature: define I2C_ARB_TIMEOUT_EN to force release of a stalled data phase after p_timeout idle cycles.
package package_i2c;
    localparam int c_burst_width = 8;
    typedef struct packed {
        logic [6:0]               dev_addr;
        logic [15:0]              reg_addr;
        logic                     we;
        logic [c_burst_width-1:0] burst_num;
    } t_i2c_cmd;
endpackage

module i2c_cmd_arbiter #(
    parameter int p_num_req     = 2,
    parameter int p_burst_width = package_i2c::c_burst_width,
    parameter int p_timeout     = 65535
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [p_num_req-1:0]                  i_req_cmd_valid,
    input  package_i2c::t_i2c_cmd [p_num_req-1:0] i_req_cmd_data,
    output logic [p_num_req-1:0]                  o_req_cmd_ready,
    input  logic [p_num_req-1:0]                  i_req_wr_valid,
    input  logic [p_num_req-1:0][7:0]             i_req_wr_data,
    output logic [p_num_req-1:0]                  o_req_wr_ready,
    output logic [p_num_req-1:0]                  o_req_rd_valid,
    output logic [7:0]                            o_req_rd_data,
    input  logic [p_num_req-1:0]                  i_req_rd_ready,
    output logic                                  o_cmd_valid,
    output package_i2c::t_i2c_cmd                 o_cmd_data,
    input  logic                                  i_cmd_ready,
    output logic                                  o_wr_valid,
    output logic [7:0]                            o_wr_data,
    input  logic                                  i_wr_ready,
    input  logic                                  i_rd_valid,
    input  logic [7:0]                            i_rd_data,
    output logic                                  o_rd_ready,
    output logic [p_num_req-1:0]                  o_grant,
    output logic                                  o_busy,
    output logic                                  o_timeout
);
    localparam int ow = p_num_req > 1 ? $clog2(p_num_req) : 1;
    localparam int cw = p_burst_width + 1;

    if (p_num_req < 1 || p_num_req > 8 || p_timeout < 1) begin : g_param_check
        $error("i2c_cmd_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} t_state;

    t_state                   state;
    logic [ow-1:0]            owner;
    logic [ow-1:0]            ptr;
    logic [ow-1:0]            pick;
    logic [ow-1:0]            next_ptr;
    logic                     found;
    logic [cw-1:0]            count;
    logic [p_burst_width-1:0] burst;
    logic                     cmd_hs;
    logic                     wr_hs;
    logic                     rd_hs;
    logic                     beat_hs;
    logic                     last_beat;
    logic                     expired;

    function automatic logic [ow-1:0] wrap(input int v);
        return (v >= p_num_req) ? ow'(v - p_num_req) : ow'(v);
    endfunction

    // Round-robin scan from the pointer; the lowest offset with a pending command wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = p_num_req - 1; i >= 0; i--) begin
            if (i_req_cmd_valid[wrap(int'(ptr) + i)]) begin
                pick  = wrap(int'(ptr) + i);
                found = 1'b1;
            end
        end
    end

    assign next_ptr  = (owner == ow'(p_num_req - 1)) ? '0 : owner + 1'b1;
    assign burst     = p_burst_width'(i_req_cmd_data[owner].burst_num);
    assign cmd_hs    = state == CMD && i_req_cmd_valid[owner] && i_cmd_ready;
    assign wr_hs     = state == WDATA && i_req_wr_valid[owner] && i_wr_ready;
    assign rd_hs     = state == RDATA && i_rd_valid && i_req_rd_ready[owner];
    assign beat_hs   = wr_hs || rd_hs;
    assign last_beat = count == cw'(1);

    assign o_cmd_valid     = state == CMD && i_req_cmd_valid[owner];
    assign o_cmd_data      = state == CMD ? i_req_cmd_data[owner] : '0;
    assign o_req_cmd_ready = (state == CMD && i_cmd_ready) ? o_grant : '0;
    assign o_wr_valid      = state == WDATA && i_req_wr_valid[owner];
    assign o_wr_data       = state == WDATA ? i_req_wr_data[owner] : 8'h00;
    assign o_req_wr_ready  = (state == WDATA && i_wr_ready) ? o_grant : '0;
    assign o_req_rd_valid  = (state == RDATA && i_rd_valid) ? o_grant : '0;
    assign o_req_rd_data   = state == RDATA ? i_rd_data : 8'h00;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int tw = $clog2(p_timeout + 1);

    logic [tw-1:0] idle_cnt;

    // Stray read bytes after a forced release are drained while IDLE.
    assign o_rd_ready = (state == RDATA && i_req_rd_ready[owner]) || (state == IDLE && i_rst_n);
    assign expired    = (state == WDATA || state == RDATA) && !beat_hs && idle_cnt == tw'(p_timeout - 1);

    // Data-phase inactivity counter; cleared by every beat and whenever the state changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            idle_cnt <= '0;
        else if ((state == WDATA || state == RDATA) && !beat_hs && !expired)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    assign o_rd_ready = state == RDATA && i_req_rd_ready[owner];
    assign expired    = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    // Arbitration and transaction sequencing; the grant is held from the command through its last data beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            count   <= '0;
            o_grant <= '0;
            o_busy  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
        end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            o_timeout <= expired;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= pick;
                        o_grant <= p_num_req'(1) << pick;
                        o_busy  <= 1'b1;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_hs) begin
                        count <= cw'(burst) + cw'(1);
                        state <= i_req_cmd_data[owner].we ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if ((beat_hs && last_beat) || expired) begin
                        state   <= IDLE;
                        ptr     <= next_ptr;
                        count   <= '0;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end else if (beat_hs) begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: scoreboard bench for i2c_cmd_arbiter driven by directed transactions.
module tb_i2c_cmd_arbiter;
    import package_i2c::*;

    localparam int n = 2;

    typedef struct packed {logic [n-1:0] g; t_i2c_cmd c;} t_exp_cmd;
    typedef struct packed {logic [n-1:0] g; logic [7:0] d;} t_exp_beat;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [n-1:0]         req_cmd_valid;
    t_i2c_cmd [n-1:0]     req_cmd_data;
    logic [n-1:0]         req_cmd_ready;
    logic [n-1:0]         req_wr_valid;
    logic [n-1:0][7:0]    req_wr_data;
    logic [n-1:0]         req_wr_ready;
    logic [n-1:0]         req_rd_valid;
    logic [7:0]           req_rd_data;
    logic [n-1:0]         req_rd_ready;
    logic                 cmd_valid;
    t_i2c_cmd             cmd_data;
    logic                 cmd_ready;
    logic                 wr_valid;
    logic [7:0]           wr_data;
    logic                 wr_ready;
    logic                 rd_valid;
    logic [7:0]           rd_data;
    logic                 rd_ready;
    logic [n-1:0]         grant;
    logic                 busy;
    logic                 timeout;

    logic                 cv [n];
    t_i2c_cmd             cd [n];
    logic                 wv [n];
    logic [7:0]           wd [n];
    logic                 rr [n];

    t_exp_cmd             exp_cmd [$];
    t_exp_beat            exp_wr [$];
    t_exp_beat            exp_rd [$];
    logic [7:0]           mq [$];
    t_exp_cmd             ec;
    t_exp_beat            eb;
    logic                 m_hs;
    int                   compared = 0;
    int                   errors = 0;

    i2c_cmd_arbiter #(.p_num_req(n), .p_burst_width(8), .p_timeout(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_cmd_valid(req_cmd_valid), .i_req_cmd_data(req_cmd_data), .o_req_cmd_ready(req_cmd_ready),
        .i_req_wr_valid(req_wr_valid), .i_req_wr_data(req_wr_data), .o_req_wr_ready(req_wr_ready),
        .o_req_rd_valid(req_rd_valid), .o_req_rd_data(req_rd_data), .i_req_rd_ready(req_rd_ready),
        .o_cmd_valid(cmd_valid), .o_cmd_data(cmd_data), .i_cmd_ready(cmd_ready),
        .o_wr_valid(wr_valid), .o_wr_data(wr_data), .i_wr_ready(wr_ready),
        .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_rd_ready(rd_ready),
        .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < n; i++) begin
            req_cmd_valid[i] = cv[i];
            req_cmd_data[i]  = cd[i];
            req_wr_valid[i]  = wv[i];
            req_wr_data[i]   = wd[i];
            req_rd_ready[i]  = rr[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        compared++;
        errors++;
        $display("FAIL %s: got no handshake required one within bound", name);
    endtask

    function automatic t_i2c_cmd mk(input logic we, input logic [7:0] b, input logic [15:0] tag);
        t_i2c_cmd c;
        c.dev_addr  = 7'h50;
        c.reg_addr  = tag;
        c.we        = we;
        c.burst_num = b;
        return c;
    endfunction

    // Monitor: pops expectations on every handshake seen on the master and requester sides.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("nonowner_leak", 64'((req_cmd_ready | req_wr_ready | req_rd_valid) & ~grant), 0);
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    compared++; errors++;
                    $display("FAIL cmd_unexpected: got %0h required none", cmd_data);
                end else begin
                    ec = exp_cmd.pop_front();
                    chk("cmd_data", 64'(cmd_data), 64'(ec.c));
                    chk("cmd_grant", 64'(grant), 64'(ec.g));
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) begin
                    compared++; errors++;
                    $display("FAIL wr_unexpected: got %0h required none", wr_data);
                end else begin
                    eb = exp_wr.pop_front();
                    chk("wr_beat", 64'({grant, wr_data}), 64'(eb));
                end
            end
            if ((req_rd_valid & req_rd_ready) != '0) begin
                if (exp_rd.size() == 0) begin
                    compared++; errors++;
                    $display("FAIL rd_unexpected: got %0h required none", req_rd_data);
                end else begin
                    eb = exp_rd.pop_front();
                    chk("rd_beat", 64'({req_rd_valid, req_rd_data}), 64'(eb));
                end
            end
        end
    end

    // Master read side: presents queued bytes and pops one per handshake.
    initial begin
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            m_hs = rd_valid && rd_ready;
            @(posedge clk);
            #1;
            if (m_hs && mq.size() > 0) void'(mq.pop_front());
            rd_valid = mq.size() > 0;
            rd_data  = rd_valid ? mq[0] : 8'h00;
        end
    end

    task automatic send_cmd(input int r, input t_i2c_cmd c);
        bit ok = 1'b0;
        cv[r] = 1'b1;
        cd[r] = c;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (req_cmd_ready[r]) ok = 1'b1;
        end
        if (!ok) bound_fail("cmd_wait");
        @(posedge clk);
        #1;
        cv[r] = 1'b0;
    endtask

    task automatic send_wr(input int r, input int cnt, input logic [7:0] base);
        for (int i = 0; i < cnt; i++) begin
            bit ok = 1'b0;
            wv[r] = 1'b1;
            wd[r] = base + 8'(i);
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk);
                if (req_wr_ready[r]) ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                bound_fail("wr_wait");
                break;
            end
        end
        wv[r] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t_i2c_cmd c, c0, c1;
        for (int i = 0; i < n; i++) begin
            cv[i] = 1'b0; cd[i] = '0; wv[i] = 1'b0; wd[i] = 8'h00; rr[i] = 1'b0;
        end
        cmd_ready = 1'b1;
        wr_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cmd_valid", 64'(cmd_valid), 0);
        chk("rst_rd_ready", 64'(rd_ready), 0);
        chk("rst_timeout", 64'(timeout), 0);
        rst_n = 1'b1;

        // Req0 write, burst 2: grant latency and in-order beats.
        c = mk(1'b1, 8'd2, 16'h0001);
        exp_cmd.push_back({2'b01, c});
        exp_wr.push_back({2'b01, 8'hA1});
        exp_wr.push_back({2'b01, 8'hA2});
        exp_wr.push_back({2'b01, 8'hA3});
        @(posedge clk);
        #1;
        cv[0] = 1'b1;
        cd[0] = c;
        @(negedge clk);
        chk("grant_before", 64'(grant), 0);
        @(negedge clk);
        chk("grant_after", 64'(grant), 64'(2'b01));
        chk("busy_cmd", 64'(busy), 1);
        chk("cmd_ready_owner", 64'(req_cmd_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        cv[0] = 1'b0;
        send_wr(0, 3, 8'hA1);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_grant", 64'(grant), 0);
        @(posedge clk);
        #1;

        // Pointer now 1: simultaneous requests serve req1 first, req0 waits.
        c0 = mk(1'b1, 8'd0, 16'h0010);
        c1 = mk(1'b1, 8'd0, 16'h0011);
        exp_cmd.push_back({2'b10, c1});
        exp_wr.push_back({2'b10, 8'hC0});
        exp_cmd.push_back({2'b01, c0});
        exp_wr.push_back({2'b01, 8'hB0});
        fork
            begin send_cmd(0, c0); send_wr(0, 1, 8'hB0); end
            begin send_cmd(1, c1); send_wr(1, 1, 8'hC0); end
        join

        // Req1 read, burst 1, with a 3-cycle requester stall.
        c = mk(1'b0, 8'd1, 16'h0020);
        exp_cmd.push_back({2'b10, c});
        exp_rd.push_back({2'b10, 8'h5C});
        exp_rd.push_back({2'b10, 8'h7E});
        mq.push_back(8'h5C);
        mq.push_back(8'h7E);
        send_cmd(1, c);
        repeat (3) begin
            @(negedge clk);
            chk("rd_stall_ready", 64'(rd_ready), 0);
            chk("rd_stall_valid", 64'(req_rd_valid), 64'(2'b10));
            @(posedge clk);
            #1;
        end
        rr[1] = 1'b1;
        begin
            bit done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                @(posedge clk);
                #1;
                if (!busy) done = 1'b1;
            end
            if (!done) bound_fail("rd_done");
        end
        rr[1] = 1'b0;
        chk("rd_all_delivered", 64'(exp_rd.size()), 0);

        // Reset in the middle of a 4-beat write after the first beat.
        c = mk(1'b1, 8'd3, 16'h0030);
        exp_cmd.push_back({2'b01, c});
        exp_wr.push_back({2'b01, 8'h10});
        send_cmd(0, c);
        send_wr(0, 1, 8'h10);
        wv[0] = 1'b1;
        wd[0] = 8'h11;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_wr_valid", 64'(wr_valid), 0);
        chk("arst_wr_ready", 64'(req_wr_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 0);
        wv[0] = 1'b0;

        // After reset: req0 first, then req1, then req0 again.
        c0 = mk(1'b1, 8'd0, 16'h0040);
        c1 = mk(1'b1, 8'd0, 16'h0041);
        c  = mk(1'b1, 8'd0, 16'h0042);
        exp_cmd.push_back({2'b01, c0});
        exp_wr.push_back({2'b01, 8'hD0});
        exp_cmd.push_back({2'b10, c1});
        exp_wr.push_back({2'b10, 8'hE0});
        exp_cmd.push_back({2'b01, c});
        exp_wr.push_back({2'b01, 8'hD1});
        fork
            begin send_cmd(0, c0); send_wr(0, 1, 8'hD0); send_cmd(0, c); send_wr(0, 1, 8'hD1); end
            begin send_cmd(1, c1); send_wr(1, 1, 8'hE0); end
        join

        // burst_num all-ones: 256 beats.
        c = mk(1'b1, 8'hFF, 16'h0050);
        exp_cmd.push_back({2'b10, c});
        for (int i = 0; i < 256; i++) exp_wr.push_back({2'b10, 8'(i)});
        send_cmd(1, c);
        send_wr(1, 256, 8'h00);
        @(negedge clk);
        chk("max_burst_idle", 64'(busy), 0);
        @(posedge clk);
        #1;

`ifdef I2C_ARB_TIMEOUT_EN
        // Read with no data: forced release after 16 idle cycles.
        c = mk(1'b0, 8'd0, 16'h0060);
        exp_cmd.push_back({2'b01, c});
        send_cmd(0, c);
        begin
            int got = 0;
            for (int k = 1; k <= 40 && got == 0; k++) begin
                @(posedge clk);
                #1;
                if (timeout) got = k;
            end
            chk("timeout_cycles", 64'(got), 16);
            chk("timeout_grant", 64'(grant), 0);
            chk("timeout_drain_ready", 64'(rd_ready), 1);
            @(posedge clk);
            #1;
            chk("timeout_pulse", 64'(timeout), 0);
        end
        c = mk(1'b1, 8'd0, 16'h0061);
        exp_cmd.push_back({2'b10, c});
        exp_wr.push_back({2'b10, 8'hF0});
        send_cmd(1, c);
        send_wr(1, 1, 8'hF0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("cmd_q_left", 64'(exp_cmd.size()), 0);
        chk("wr_q_left", 64'(exp_wr.size()), 0);
        chk("rd_q_left", 64'(exp_rd.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end
endmodule
